prv32_mdu: RTL and testbench

//  Parametrised iterative RV32M multiply/divide unit, successor to the single-cycle combinational M ops in the ALU.

---
 rtl/prv32_mdu.sv | 195 +++++++++++++++++++
 tb/tb_prv32_mdu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prv32_mdu.sv
// prv32_mdu: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle).
// Optional build macro PRV32_MDU_FAST_MUL_EN: all multiplies resolve in one cycle at accept.
module prv32_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [2*XLEN-1:0] ZERO2    = {(2*XLEN){1'b0}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic [2:0]         op_r;
  logic [TAG_W-1:0]   tag_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r;
  logic [XLEN-1:0]    dsr_r, hi_r, lo_r, result_r;

  logic               accept_s, a_signed_s, b_signed_s, sa_s, sb_s, neg_s;
  logic               div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0]    abs_a_s, abs_b_s, special_res_s, hi_nxt_s, lo_nxt_s, final_res_s;
  logic [XLEN:0]      mul_sum_s, div_trial_s;
  logic [2*XLEN-1:0]  prod_s, prod_fix_s;

  assign accept_s   = in_valid & (state_r == ST_IDLE);
  assign a_signed_s = (in_op == 3'd1) | (in_op == 3'd2) | (in_op == 3'd4) | (in_op == 3'd6);
  assign b_signed_s = (in_op == 3'd1) | (in_op == 3'd4) | (in_op == 3'd6);
  assign sa_s       = a_signed_s & in_a[XLEN-1];
  assign sb_s       = b_signed_s & in_b[XLEN-1];
  assign abs_a_s    = sa_s ? (ZERO - in_a) : in_a;
  assign abs_b_s    = sb_s ? (ZERO - in_b) : in_b;
  // Remainder follows the dividend sign; everything else follows sa^sb (sb is 0 where b is unsigned).
  assign neg_s      = (in_op == 3'd6) ? sa_s : (sa_s ^ sb_s);
  assign div_zero_s = in_op[2] & (in_b == ZERO);
  assign div_ovf_s  = in_op[2] & ~in_op[0] & (in_a == MIN_INT) & (in_b == ALL_ONES);

`ifdef PRV32_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a_s, fm_b_s, fm_prod_s;
  assign fm_a_s    = {{XLEN{sa_s}}, in_a};
  assign fm_b_s    = {{XLEN{sb_s}}, in_b};
  assign fm_prod_s = fm_a_s * fm_b_s;
  assign special_s = div_zero_s | div_ovf_s | ~in_op[2];
`else
  assign special_s = div_zero_s | div_ovf_s;
`endif

  // Early-out result selection for ops that skip iteration.
  always_comb begin
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = in_op[1] ? in_a : ALL_ONES;
    end else if (div_ovf_s) begin
      special_res_s = in_op[1] ? ZERO : MIN_INT;
    end else begin
`ifdef PRV32_MDU_FAST_MUL_EN
      special_res_s = (in_op == 3'd0) ? fm_prod_s[XLEN-1:0] : fm_prod_s[2*XLEN-1:XLEN];
`else
      special_res_s = ZERO;
`endif
    end
  end

  // hi_r/lo_r hold {partial product, multiplier} for multiply and {remainder, dividend} for divide.
  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dsr_r} : {(XLEN+1){1'b0}});
  assign div_trial_s = {hi_r, lo_r[XLEN-1]} - {1'b0, dsr_r};

  // One shift-add or restoring-subtract step.
  always_comb begin
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (!op_r[2]) begin
      hi_nxt_s = mul_sum_s[XLEN:1];
      lo_nxt_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end else if (!div_trial_s[XLEN]) begin
      hi_nxt_s = div_trial_s[XLEN-1:0];
      lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
      lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
    end
  end

  assign prod_s     = {hi_nxt_s, lo_nxt_s};
  assign prod_fix_s = neg_r ? (ZERO2 - prod_s) : prod_s;

  // Sign fix-up and result selection on the last iteration.
  always_comb begin
    final_res_s = ZERO;
    case (op_r)
      3'd0:                final_res_s = prod_fix_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          final_res_s = neg_r ? (ZERO - lo_nxt_s) : lo_nxt_s;
      3'd6, 3'd7:          final_res_s = neg_r ? (ZERO - hi_nxt_s) : hi_nxt_s;
      default:             final_res_s = ZERO;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (flush) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = special_s ? ST_DONE : ST_BUSY;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = ST_DONE;
        else                        state_nxt_s = ST_BUSY;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_BUSY: out_valid = 1'b0;
      ST_DONE: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: latch request, iterate, capture result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r     <= 3'd0;
      tag_r    <= {TAG_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      neg_r    <= 1'b0;
      dsr_r    <= ZERO;
      hi_r     <= ZERO;
      lo_r     <= ZERO;
      result_r <= ZERO;
    end else if (flush) begin
      cnt_r    <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= in_op;
      tag_r    <= in_tag;
      neg_r    <= neg_s;
      cnt_r    <= CNT_W'(XLEN - 1);
      hi_r     <= ZERO;
      lo_r     <= in_op[2] ? abs_a_s : abs_b_s;
      dsr_r    <= in_op[2] ? abs_b_s : abs_a_s;
      if (special_s) result_r <= special_res_s;
    end else if (state_r == ST_BUSY) begin
      hi_r <= hi_nxt_s;
      lo_r <= lo_nxt_s;
      if (cnt_r == {CNT_W{1'b0}}) result_r <= final_res_s;
      else                        cnt_r    <= cnt_r - CNT_W'(1);
    end
  end

  assign out_result = result_r;
  assign out_tag    = tag_r;
endmodule

// File: tb/tb_prv32_mdu.sv
// tb_prv32_mdu: randomized scoreboard bench for prv32_mdu with an arithmetic reference model.
// Honours PRV32_MDU_FAST_MUL_EN for the expected multiply latency.
module tb_prv32_mdu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_a = 32'd0, in_b = 32'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  prv32_mdu #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic [4:0] tag; int lat; int acc; } exp_t;
  exp_t sb_q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit rand_rdy = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: if (b == 32'd0) p = 64'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, a};
            else p = sa / sb;
      3'd5: if (b == 32'd0) p = 64'hFFFFFFFF; else p = ua / ub;
      3'd6: if (b == 32'd0) p = {32'd0, a};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = 64'd0;
            else p = sa % sb;
      3'd7: if (b == 32'd0) p = {32'd0, a}; else p = ua % ub;
      default: p = 64'd0;
    endcase
    if (op >= 3'd1 && op <= 3'd3) return p[63:32];
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef PRV32_MDU_FAST_MUL_EN
    if (op < 3'd4) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request when the unit is ready; optionally record the expected response.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_res, input bit track);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", n);
      return;
    end
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    if (track) begin
      e.res = exp_res; e.tag = tag; e.lat = ref_lat(op, a, b); e.acc = cyc;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: latency on the rising edge of out_valid, result/tag on each handshake.
  initial begin
    bit prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          if (!prev_v) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: result 0x%08h tag %0d with empty scoreboard", out_result, out_tag);
          end
        end else begin
          if (!prev_v) begin
            checks++;
            if (cyc - sb_q[0].acc != sb_q[0].lat) begin
              errors++;
              $display("FAIL latency: got %0d expected %0d (tag %0d)", cyc - sb_q[0].acc, sb_q[0].lat, sb_q[0].tag);
            end
          end
          if (out_ready) begin
            checks++;
            if (out_result !== sb_q[0].res || out_tag !== sb_q[0].tag) begin
              errors++;
              $display("FAIL result: got 0x%08h/%0d expected 0x%08h/%0d",
                       out_result, out_tag, sb_q[0].res, sb_q[0].tag);
            end
            void'(sb_q.pop_front());
          end
        end
      end
      prev_v = out_valid;
    end
  end

  initial forever begin
    tick();
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, hold_exp;
    int n;
    repeat (3) tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_tag", {27'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      issue(d_op[i], d_a[i], d_b[i], (i == 0) ? 5'd5 : 5'(i), d_exp[i], 1'b1);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(op, a, b, 5'($urandom_range(0, 31)), ref_res(op, a, b), 1'b1);
    end
    rand_rdy = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();

    // Result held in DONE while the consumer stalls; extra requests must be ignored.
    out_ready = 1'b0;
    a = 32'hFFFFFF9C;
    b = 32'd7;
    hold_exp = ref_res(3'd4, a, b);
    issue(3'd4, a, b, 5'd9, hold_exp, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_result", out_result, hold_exp);
      chk("hold_tag", {27'd0, out_tag}, 32'd9);
      in_valid = i[0];
      in_op = 3'd0; in_a = 32'd3; in_b = 32'd3; in_tag = 5'd1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in BUSY cycle 10, then flush racing an IDLE request, then reset mid-op.
    issue(3'd5, 32'd1000, 32'd3, 5'd3, 32'd0, 1'b0);
    repeat (9) tick();
    chk("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd9; in_b = 32'd0; in_tag = 5'd4; flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_drops_request", {31'd0, busy}, 32'd0);
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd7, 32'd0, 1'b0);
    repeat (15) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midop_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midop_reset_busy", {31'd0, busy}, 32'd0);
    chk("midop_reset_result", out_result, 32'd0);
    chk("midop_reset_tag", {27'd0, out_tag}, 32'd0);
    repeat (40) tick();
    chk("aborted_never_valid", {31'd0, out_valid}, 32'd0);

    issue(3'd7, 32'd100, 32'd7, 5'd30, ref_res(3'd7, 32'd100, 32'd7), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
